// File: rtl/tx_sample_packer.sv
// tx_sample_packer: splits 32-bit framed I/Q host samples into two 16-bit TX FIFO words.
// Optional framing check enabled by defining TX_PACKER_FRAME_CHECK_EN.
module tx_sample_packer #(
   parameter int CNT_W = 16
) (
   input  logic             i_sys_clk,
   input  logic             i_rst,
   input  logic             i_tx_enable,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic [31:0]      i_s_data,
   output logic             o_fifo_wr_en,
   output logic [15:0]      o_fifo_wr_data,
   input  logic             i_fifo_full,
   output logic [CNT_W-1:0] o_sample_count,
   output logic [7:0]       o_err_count,
   output logic             o_busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_t;
   state_t             state_q, state_d;
   logic [31:0]        hold_q, hold_d;
   logic               wr_en_q, wr_en_d;
   logic [15:0]        wr_data_q, wr_data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               xfer;
   logic               bad;
   assign o_s_ready      = (state_q == IDLE) || (state_q == LO && !i_fifo_full);
   assign xfer           = i_s_valid && o_s_ready;
   assign o_busy         = state_q != IDLE;
   assign o_fifo_wr_en   = wr_en_q;
   assign o_fifo_wr_data = wr_data_q;
   assign o_sample_count = cnt_q;
`ifdef TX_PACKER_FRAME_CHECK_EN
   logic [7:0] err_q, err_d;
   assign bad = (i_s_data[31:30] != 2'b10) || (i_s_data[15:14] != 2'b01) || i_s_data[16] || i_s_data[0];
   assign o_err_count = err_q;
   // saturating count of malformed samples dropped at acceptance
   always_comb err_d = (xfer && i_tx_enable && bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   // error counter register
   always_ff @(posedge i_sys_clk or posedge i_rst)
      if (i_rst) err_q <= 8'h00;
      else       err_q <= err_d;
`else
   assign bad         = 1'b0;
   assign o_err_count = 8'h00;
`endif
   // drain the held pair high word first, then evaluate a new acceptance (also in the LO write cycle)
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      cnt_d     = cnt_q;
      case (state_q)
         HI: if (!i_fifo_full) begin
            wr_en_d   = 1'b1;
            wr_data_d = hold_q[31:16];
            state_d   = LO;
         end
         LO: if (!i_fifo_full) begin
            wr_en_d   = 1'b1;
            wr_data_d = hold_q[15:0];
            cnt_d     = cnt_q + CNT_W'(1);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (xfer) begin
         hold_d  = i_s_data;
         state_d = (i_tx_enable && !bad) ? HI : IDLE;
      end
   end
   // state, hold and registered FIFO write port
   always_ff @(posedge i_sys_clk or posedge i_rst)
      if (i_rst) begin
         state_q   <= IDLE;
         hold_q    <= 32'h0;
         wr_en_q   <= 1'b0;
         wr_data_q <= 16'h0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         cnt_q     <= cnt_d;
      end
endmodule

// File: tb/tb_tx_sample_packer.sv
// tb_tx_sample_packer: randomized bench checking tx_sample_packer against a word-queue model.
module tb_tx_sample_packer;
`ifdef TX_PACKER_FRAME_CHECK_EN
   localparam bit FC = 1'b1;
`else
   localparam bit FC = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0, valid = 1'b0, full = 1'b0;
   logic [31:0] data = 32'h0;
   logic        ready, wr_en, busy;
   logic [15:0] wr_data, cnt;
   logic [7:0]  err;
   int          vec = 0, errs = 0;

   tx_sample_packer #(.CNT_W(16)) dut (
      .i_sys_clk(clk), .i_rst(rst), .i_tx_enable(en), .i_s_valid(valid),
      .o_s_ready(ready), .i_s_data(data), .o_fifo_wr_en(wr_en),
      .o_fifo_wr_data(wr_data), .i_fifo_full(full), .o_sample_count(cnt),
      .o_err_count(err), .o_busy(busy));

   always #5 clk = ~clk;

   // model: queue of words still owed to the FIFO
   logic [15:0] q[$];
   logic        m_wr_en = 1'b0;
   logic [15:0] m_wr_data = 16'h0;
   logic [15:0] m_cnt = 16'h0;
   logic [7:0]  m_err = 8'h0;
   bit          rdy;

   function automatic bit malformed(logic [31:0] d);
      return (d[31:30] != 2'b10) || (d[15:14] != 2'b01) || d[16] || d[0];
   endfunction

   function automatic logic [31:0] mk(logic [12:0] i, logic [12:0] qv);
      return {2'b10, i, 1'b0, 2'b01, qv, 1'b0};
   endfunction

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      vec++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_wr_en   <= 1'b0;
         m_wr_data <= 16'h0;
         m_cnt     <= 16'h0;
         m_err     <= 8'h0;
      end else begin
         rdy = (q.size() == 0) || (q.size() == 1 && !full);
         m_wr_en <= 1'b0;
         if (q.size() != 0 && !full) begin
            m_wr_en   <= 1'b1;
            m_wr_data <= q.pop_front();
            if (q.size() == 0) m_cnt <= m_cnt + 16'd1;
         end
         if (valid && rdy && en) begin
            if (FC && malformed(data)) m_err <= (m_err == 8'hFF) ? m_err : m_err + 8'd1;
            else begin
               q.push_back(data[31:16]);
               q.push_back(data[15:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("ready", ready, (q.size() == 0) || (q.size() == 1 && !full));
      chk("busy", busy, q.size() != 0);
      chk("wr_en", wr_en, m_wr_en);
      if (m_wr_en) chk("wr_data", wr_data, m_wr_data);
      chk("sample_count", cnt, m_cnt);
      chk("err_count", err, m_err);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [31:0] d);
      valid = 1'b1; data = d;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      logic [15:0] c0;
      rst = 1'b1;
      tick(); tick();
      chk("rst wr_en", wr_en, 0); chk("rst wr_data", wr_data, 16'h0);
      chk("rst count", cnt, 0);   chk("rst ready", ready, 1); chk("rst busy", busy, 0);
      rst = 1'b0; en = 1'b1;
      tick();
      send(32'h8002_4004);
      chk("accept busy", busy, 1); chk("accept wr_en", wr_en, 0);
      tick(); chk("hi wr_en", wr_en, 1); chk("hi data", wr_data, 16'h8002);
      tick(); chk("lo wr_en", wr_en, 1); chk("lo data", wr_data, 16'h4004);
      chk("count 1", cnt, 1);
      tick();
      // four back-to-back samples: eight consecutive writes
      valid = 1'b1; data = mk(13'd1, 13'd2);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i % 2 == 0) data = mk(13'(i + 3), 13'(i + 4));
         if (i == 6) valid = 1'b0;
         if (i >= 1 && i <= 8) chk("b2b wr_en", wr_en, 1);
      end
      chk("count 5", cnt, 5);
      // full in HI stalls for five cycles
      send(mk(13'h1ABC, 13'h0123));
      full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(); chk("stall wr_en", wr_en, 0); chk("stall ready", ready, 0);
      end
      full = 1'b0;
      tick(); chk("post stall hi", wr_data, 16'hB578); chk("post stall wr", wr_en, 1);
      tick(); chk("post stall lo", wr_data, 16'h4246);
      tick();
      // malformed word
      send(32'h0002_4004);
      tick(); chk("malformed wr_en", wr_en, !FC);
      tick(); tick();
      chk("err 1", err, FC ? 1 : 0);
      valid = 1'b1; data = 32'h0002_4004;
      for (int i = 0; i < 300; i++) tick();
      valid = 1'b0;
      tick(); tick(); tick();
      chk("err sat", err, FC ? 255 : 0);
      // enable drop after acceptance still completes the pair
      c0 = cnt;
      send(mk(13'd7, 13'd9));
      en = 1'b0;
      tick(); tick();
      chk("en drop count", cnt, c0 + 16'd1);
      send(mk(13'd5, 13'd5));
      chk("disabled busy", busy, 0);
      tick(); chk("disabled wr_en", wr_en, 0); chk("disabled count", cnt, c0 + 16'd1);
      // reset in LO with full
      en = 1'b1;
      send(mk(13'd3, 13'd3));
      tick();
      full = 1'b1;
      tick();
      rst = 1'b1;
      #1;
      chk("rst lo wr_en", wr_en, 0); chk("rst lo data", wr_data, 0); chk("rst lo count", cnt, 0);
      chk("rst lo busy", busy, 0);   chk("rst lo ready", ready, 1); chk("rst lo err", err, 0);
      tick();
      rst = 1'b0; full = 1'b0;
      tick();
      send(32'h8002_4004);
      tick(); chk("after rst hi", wr_data, 16'h8002);
      tick(); chk("after rst lo", wr_data, 16'h4004); chk("after rst count", cnt, 1);
      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         valid = ($urandom_range(0, 9) < 7);
         en    = ($urandom_range(0, 19) != 0);
         full  = ($urandom_range(0, 9) < 3);
         data  = ($urandom_range(0, 3) != 0) ? mk(13'($urandom), 13'($urandom)) : $urandom;
         rst   = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; valid = 1'b0; full = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/tx_sample_packer.md
# tx_sample_packer

Splits 32-bit I/Q TX samples from the host SMI write path into the pair of 16-bit words the TX sample FIFO carries. Sits directly upstream of the TX FIFO that feeds the LVDS TX serializer, in the `i_sys_clk` domain: host sample stream in, FIFO write port out. Checks each sample's framing bits, drops and counts malformed samples, and gates output with a TX enable.

## Interface
Parameters:
- CNT_W, 16, width of the forwarded-sample counter

Ports:
- i_sys_clk  in  1  system clock; the only clock
- i_rst  in  1  reset, asynchronous, active-high
- i_tx_enable  in  1  1 = forward samples to FIFO; 0 = accept and discard
- i_s_valid  in  1  input sample valid
- o_s_ready  out  1  block accepts the sample this cycle
- i_s_data  in  32  sample {2'b10, I[12:0], 1'b0, 2'b01, Q[12:0], 1'b0}
- o_fifo_wr_en  out  1  FIFO write strobe, one word per cycle
- o_fifo_wr_data  out  16  FIFO word
- i_fifo_full  in  1  FIFO full; no write is issued while high
- o_sample_count  out  CNT_W  samples fully written to FIFO, wraps
- o_err_count  out  8  malformed samples dropped, saturating
- o_busy  out  1  a sample is held (state HI or LO)

## Operation
- Input handshake: transfer when i_s_valid && o_s_ready. Accepted word is captured in a 32-bit hold register.
- States: IDLE, HI, LO.
- IDLE: o_s_ready=1. On transfer:
  - If i_tx_enable=0: sample discarded; stay IDLE.
  - If malformed (macro enabled): discarded, o_err_count+1; stay IDLE.
  - Otherwise: go to HI.
- Malformed means i_s_data[31:30]!=2'b10, or [15:14]!=2'b01, or [16]!=0, or [0]!=0.
- HI: if !i_fifo_full, write hold[31:16] and go to LO. Otherwise hold, with no write.
- LO: if !i_fifo_full, write hold[15:0] and increment o_sample_count. In that same cycle o_s_ready=1 and a new transfer is evaluated exactly as in IDLE (valid goes to HI, else IDLE). If i_fifo_full, hold and o_s_ready=0.
- o_s_ready = (state==IDLE) || (state==LO && !i_fifo_full). It is combinational from state and i_fifo_full only, never from i_s_valid.
- i_tx_enable falling while in HI/LO: the held sample still completes both writes. A pair is never split.
- i_tx_enable is sampled only at acceptance.
- o_sample_count wraps 2^CNT_W-1 -> 0. o_err_count saturates at 255.
- o_busy = (state != IDLE).

## Timing
- Reset (async assert, released synchronously to i_sys_clk):
  - state=IDLE, o_s_ready=1, o_fifo_wr_en=0, o_fifo_wr_data=16'h0000
  - o_sample_count=0, o_err_count=0, o_busy=0, hold register=0
- o_fifo_wr_en and o_fifo_wr_data are registered.
- Latency: sample accepted at edge N. HI word written at edge N+1 (wr_en high in cycle N+1), LO word at edge N+2, assuming not full.
- Throughput: 1 sample / 2 clocks sustained, with no idle cycle between samples.
- i_fifo_full is sampled combinationally in the cycle of the write decision. The FIFO must assert full with one word of slack or better.
- Reset mid-operation discards any held sample. A half-written pair (HI without LO) can reach the FIFO. Downstream resynchronizes on its framing bits.
- Simultaneous LO write + new accept + malformed: LO write and o_sample_count increment happen, and o_err_count increments, in the same cycle.

## Configuration
- TX_PACKER_FRAME_CHECK_EN defined: framing check active; malformed samples dropped and counted in o_err_count.
- Undefined: no check; every accepted sample with i_tx_enable=1 is forwarded; o_err_count tied to 8'h00.

## Test plan
- Reset then i_s_data=32'h8002_4004 valid, enable=1, full=0 -> wr_data 16'h8002 at cycle+1, 16'h4004 at cycle+2; o_sample_count=1.
- 4 back-to-back valid samples -> 8 consecutive wr_en cycles with no gap; o_s_ready high during each LO cycle; o_sample_count=4.
- i_fifo_full high while in HI for 5 cycles -> no write and o_s_ready=0 for 5 cycles; HI word written the cycle after full drops; data unchanged.
- With TX_PACKER_FRAME_CHECK_EN, send 32'h0002_4004 -> no FIFO write, o_err_count=1. Send 300 such words -> o_err_count=255. Without the macro -> the same word is forwarded and o_err_count=0.
- Deassert i_tx_enable the cycle after acceptance -> both words still written. Next sample while disabled is accepted, no write, count unchanged.
- Assert i_rst in LO with full=1 -> all outputs at reset values immediately; a next sample after release is written normally.
